// File: rtl/mem_pkg.sv
// mem_pkg: clear FSM state type and default sizing constants shared by data_mem_dualport and mem_clear_fsm
package mem_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;
  localparam int DATA_W_DEF    = 32;
  localparam int DEPTH_DEF     = 328;
  localparam int VID_BASE_DEF  = 0;
  localparam int VID_WORDS_DEF = 256;
endpackage

// File: rtl/mem_clear_fsm.sv
// mem_clear_fsm: zeroes display words one per cycle, stalls while i_stall; ports clk/rst_n, i_start, i_stall -> o_we, o_idx, o_busy, o_done
module mem_clear_fsm
  import mem_pkg::*;
#(
  parameter int VID_WORDS = VID_WORDS_DEF,
  localparam int PW = $clog2(VID_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_stall,
  output logic          o_we,
  output logic [PW-1:0] o_idx,
  output logic          o_busy,
  output logic          o_done
);
  clr_state_t    r_state;
  logic [PW-1:0] r_ptr;
  logic          r_busy;
  logic          r_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_state <= CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
        CLEAR: if (!i_stall) begin
          r_ptr <= r_ptr + PW'(1);
          if (r_ptr == PW'(VID_WORDS - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign o_we   = (r_state == CLEAR) && !i_stall;
  assign o_idx  = r_ptr;
  assign o_busy = r_busy;
  assign o_done = r_done;
endmodule

// File: rtl/data_mem_dualport.sv
// data_mem_dualport: byte-lane CPU port (comb read, err pulse), registered display read port, hardware clear of the display region
module data_mem_dualport
  import mem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int VID_BASE  = VID_BASE_DEF,
  parameter int VID_WORDS = VID_WORDS_DEF,
  localparam int NB = DATA_W / 8,
  localparam int AW = $clog2(DEPTH),
  localparam int VW = $clog2(VID_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic [NB-1:0]     cpu_be,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              vid_req,
  input  logic [VW-1:0]     vid_idx,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [29:0]       r_prev_idx;
  logic              r_err;
  logic              r_vid_valid;
  logic [DATA_W-1:0] r_vid_data;
  logic [29:0]       w_idx;
  logic              w_ok;
  logic              w_cpu_we;
  logic              w_clr_we;
  logic [VW-1:0]     w_clr_idx;
  logic              w_we;
  logic [AW-1:0]     w_widx;
  logic [DATA_W-1:0] w_wdata;
  logic [NB-1:0]     w_be;
  logic [AW-1:0]     w_vaddr;
  logic              w_unused;
  assign w_unused  = ^cpu_addr[1:0];
  assign w_idx     = cpu_addr[31:2];
  assign w_ok      = w_idx < 30'(DEPTH);
  assign w_cpu_we  = cpu_we && w_ok;
  assign cpu_rdata = w_ok ? r_mem[w_idx[AW-1:0]] : '0;
  mem_clear_fsm #(.VID_WORDS(VID_WORDS)) u_clr (
    .clk     (clk),
    .rst_n   (reset),
    .i_start (clr_start),
    .i_stall (w_cpu_we),
    .o_we    (w_clr_we),
    .o_idx   (w_clr_idx),
    .o_busy  (clr_busy),
    .o_done  (clr_done)
  );
  // single write port: a CPU write wins and stalls the clear for that cycle
  assign w_we    = w_cpu_we || w_clr_we;
  assign w_widx  = w_cpu_we ? w_idx[AW-1:0] : AW'(VID_BASE) + AW'(w_clr_idx);
  assign w_wdata = w_cpu_we ? cpu_wdata : '0;
  assign w_be    = w_cpu_we ? cpu_be : '1;
  assign w_vaddr = AW'(VID_BASE) + AW'(vid_idx);
  always_ff @(posedge clk)
    if (w_we)
      for (int b = 0; b < NB; b++)
        if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_prev_idx  <= '0;
      r_err       <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
    end else begin
      r_prev_idx  <= w_idx;
      r_err       <= !w_ok && (cpu_we || w_idx != r_prev_idx);
      r_vid_valid <= vid_req;
      if (vid_req) r_vid_data <= r_mem[w_vaddr];
    end
  assign cpu_err   = r_err;
  assign vid_valid = r_vid_valid;
  assign vid_data  = r_vid_data;
endmodule

// File: tb/tb_data_mem_dualport.sv
// tb_data_mem_dualport: random and directed checks of data_mem_dualport against an array reference model
module tb_data_mem_dualport;
  localparam int DEPTH = 328;
  localparam int VB    = 0;
  localparam int VW    = 256;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_be = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        vid_req = 1'b0;
  logic [7:0]  vid_idx = '0;
  logic        vid_valid;
  logic [31:0] vid_data;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        clr_done;
  always #5 clk = ~clk;
  data_mem_dualport dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .vid_req(vid_req), .vid_idx(vid_idx),
    .vid_valid(vid_valid), .vid_data(vid_data), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
  );
  logic [31:0] model [DEPTH];
  logic [29:0] m_prev = '0;
  logic        e_err = 1'b0;
  logic        e_vv = 1'b0;
  logic [31:0] e_vd = '0;
  logic        keep [VW];
  int total = 0;
  int bad = 0;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, o, e);
    end
  endtask
  task automatic cyc();
    logic [29:0] ix;
    ix = cpu_addr[31:2];
    e_err = (ix >= 30'(DEPTH)) && (cpu_we || ix != m_prev);
    e_vv = vid_req;
    if (vid_req) e_vd = model[VB + int'(vid_idx)];
    if (cpu_we && ix < 30'(DEPTH))
      for (int b = 0; b < 4; b++)
        if (cpu_be[b]) model[ix][8*b +: 8] = cpu_wdata[8*b +: 8];
    m_prev = ix;
    @(posedge clk);
    #1;
    chk("cpu_err", {31'd0, cpu_err}, {31'd0, e_err});
    chk("vid_valid", {31'd0, vid_valid}, {31'd0, e_vv});
    chk("vid_data", vid_data, e_vd);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_addr = a;
    cpu_wdata = d;
    cpu_be = be;
    cpu_we = 1'b1;
    cyc();
    cpu_we = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input int w);
    cpu_addr = 32'(w) * 4;
    #1;
    chk(tag, cpu_rdata, model[w]);
  endtask
  task automatic run_clear(input bit stall, input int exp_cycles);
    int ks [3] = '{50, 80, 120};
    int os [3] = '{10, 200, 116};
    int s = 0;
    int busy_n = 0;
    int done_at = 0;
    for (int o = 0; o < VW; o++) keep[o] = 1'b0;
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (clr_busy) busy_n++;
      if (clr_done) done_at = k;
      if (!clr_busy) break;
      for (int j = 0; j < 3; j++)
        if (stall && k == ks[j]) begin
          // words below offset k-1-s are already cleared, so this write survives
          if (os[j] < k - 1 - s) keep[os[j]] = 1'b1;
          s++;
          cpu_addr = 32'(VB + os[j]) * 4;
          cpu_wdata = $urandom;
          cpu_be = 4'hF;
          cpu_we = 1'b1;
        end
      cyc();
      cpu_we = 1'b0;
    end
    chk("clr_busy_cycles", 32'(busy_n), 32'(exp_cycles));
    chk("clr_done_cycle", 32'(done_at), 32'(exp_cycles));
    for (int o = 0; o < VW; o++) if (!keep[o]) model[VB + o] = '0;
    for (int w = VB; w <= VB + VW; w++) rd_chk("clear_word", w);
  endtask
  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_done", {31'd0, clr_done}, 32'd0);
    chk("rst_vvalid", {31'd0, vid_valid}, 32'd0);
    chk("rst_vdata", vid_data, 32'd0);
    chk("rst_err", {31'd0, cpu_err}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int w = 0; w < DEPTH; w++) wr(32'(w) * 4 | ($urandom % 4), $urandom, 4'hF);
    repeat (20) rd_chk("fill_read", int'($urandom_range(0, DEPTH - 1)));
    repeat (30) begin
      int w;
      w = int'($urandom_range(0, DEPTH - 1));
      wr(32'(w) * 4 | ($urandom % 4), $urandom, 4'($urandom));
      rd_chk("be_read", w);
    end
    wr(32'h10, 32'hAABBCCDD, 4'hF);
    wr(32'h10, 32'h00001100, 4'b0010);
    cpu_addr = 32'h10;
    #1 chk("byte_lane", cpu_rdata, 32'hAABB11DD);
    wr(4 * DEPTH, 32'hDEADBEEF, 4'hF);
    chk("oob_err_pulse", {31'd0, cpu_err}, 32'd1);
    chk("oob_rdata", cpu_rdata, 32'd0);
    cyc();
    cpu_addr = 32'h8000_0000;
    cyc();
    cpu_addr = 4 * 400;
    cyc();
    rd_chk("oob_nochg_last", DEPTH - 1);
    rd_chk("oob_nochg_first", 0);
    cyc();
    wr(32'(VB + 5) * 4, 32'h12345678, 4'hF);
    vid_req = 1'b1;
    vid_idx = 8'd5;
    cyc();
    chk("vid_latency", vid_data, 32'h12345678);
    vid_idx = 8'd7;
    wr(32'(VB + 7) * 4, $urandom, 4'hF);
    repeat (60) begin
      vid_req = ($urandom % 3) != 0;
      vid_idx = 8'($urandom);
      cpu_we = $urandom % 2 == 1;
      cpu_addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
      cpu_wdata = $urandom;
      cpu_be = 4'($urandom);
      cyc();
    end
    cpu_we = 1'b0;
    vid_req = 1'b0;
    cyc();
    for (int o = 0; o < VW; o++) wr(32'(VB + o) * 4, 32'hFFFFFFFF, 4'hF);
    wr(32'(VB + VW) * 4, 32'hC0FFEE00, 4'hF);
    run_clear(1'b0, VW + 1);
    for (int o = 0; o < VW; o++) wr(32'(VB + o) * 4, 32'hFFFFFFFF, 4'hF);
    run_clear(1'b1, VW + 4);
    for (int o = 0; o < VW; o++) wr(32'(VB + o) * 4, $urandom, 4'hF);
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    repeat (100) cyc();
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_mid_done", {31'd0, clr_done}, 32'd0);
    e_vv = 1'b0;
    e_vd = '0;
    m_prev = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int o = 0; o < 100; o++) model[VB + o] = '0;
    for (int w = VB; w <= VB + VW; w++) rd_chk("rst_clear_word", w);
    vid_req = 1'b1;
    vid_idx = 8'd150;
    cyc();
    vid_req = 1'b0;
    cyc();
    chk("vid_hold", vid_data, model[VB + 150]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_dualport.md
DATA_MEM_DUALPORT -- requirements
Module: data_mem_dualport

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 328: number of words in the memory array.
REQ-003 SHALL have parameter VID_BASE, default 0: first word index of the display region.
REQ-004 SHALL have parameter VID_WORDS, default 256: number of words in the display region; VID_BASE+VID_WORDS <= DEPTH.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port cpu_addr, input, 32: byte address; word index = cpu_addr[31:2]; bits [1:0] are ignored.
REQ-008 SHALL have port cpu_wdata, input, DATA_W: write data.
REQ-009 SHALL have port cpu_we, input, 1: write enable.
REQ-010 SHALL have port cpu_be, input, DATA_W/8: byte enables; bit i enables byte lane i.
REQ-011 SHALL have port cpu_rdata, output, DATA_W: combinational read data.
REQ-012 SHALL have port cpu_err, output, 1: registered pulse flagging an out-of-range access.
REQ-013 SHALL have port vid_req, input, 1: display read request.
REQ-014 SHALL have port vid_idx, input, $clog2(VID_WORDS): offset into the display region.
REQ-015 SHALL have port vid_valid, output, 1: vid_data is valid.
REQ-016 SHALL have port vid_data, output, DATA_W: display read data.
REQ-017 SHALL have port clr_start, input, 1: one-cycle pulse that starts a hardware clear.
REQ-018 SHALL have port clr_busy, output, 1: clear in progress.
REQ-019 SHALL have port clr_done, output, 1: one-cycle pulse when a clear completes.

Function
REQ-020 SHALL return cpu_rdata = mem[word index] combinationally for word index < DEPTH, else 0, so a single-cycle datapath uses it within the same cycle.
REQ-021 SHALL write only the byte lanes enabled by cpu_be on a rising edge with cpu_we=1 and word index < DEPTH; lanes not enabled keep their value.
REQ-022 SHALL ignore any write with word index >= DEPTH.
REQ-023 SHALL assert cpu_err for one cycle after any cycle in which cpu_we=1 or cpu_addr changes to a word index >= DEPTH; the registered pulse is computed from that cycle's inputs.
REQ-024 SHALL register the display read as vid_data = mem[VID_BASE+vid_idx] with vid_valid=1 in the cycle after a cycle with vid_req=1; 1-cycle latency; a request accepted every cycle.
REQ-025 SHALL make vid_valid=0 in the cycle after vid_req=0, while vid_data holds its last value.
REQ-026 SHALL give a display read and a write to the same word in the same cycle read-before-write behaviour: vid_data carries the old value.
REQ-027 SHALL use clear FSM states IDLE, CLEAR and DONE.
REQ-028 SHALL move IDLE->CLEAR on clr_start=1 and load the clear pointer with 0.
REQ-029 SHALL, in CLEAR, write 0 to mem[VID_BASE+ptr] and increment ptr; on the cycle ptr = VID_WORDS-1 is written, move to DONE.
REQ-030 SHALL move DONE->IDLE unconditionally; clr_done=1 only in DONE.
REQ-031 SHALL hold clr_busy=1 in CLEAR and DONE.
REQ-032 SHALL ignore clr_start while not in IDLE.
REQ-033 SHALL, on a cycle in CLEAR where the CPU writes any valid address, apply the CPU write, not write the clear word and not advance ptr; the clear takes exactly VID_WORDS cycles plus one per stalled cycle.
REQ-034 SHALL not block CPU or display reads during a clear; they return current array contents.

Reset
REQ-035 SHALL, while reset=0, force the FSM to IDLE, ptr=0, clr_busy=0, clr_done=0, vid_valid=0, vid_data=0 and cpu_err=0 asynchronously.
REQ-036 SHALL not initialise memory contents on reset; a clear interrupted by reset leaves the remaining words unchanged.

Structure
REQ-037 SHALL take the clear FSM state enum and default parameter constants from the shared package mem_pkg.
REQ-038 SHALL implement the clear engine as sub-module mem_clear_fsm, which outputs the write enable, the index, busy and done.
REQ-039 SHALL hold the memory array in this module, using a single write mux arbitrated CPU-first.

Verification
REQ-040 SHALL check a byte-lane write: write 0xAABBCCDD to addr 0x10, then addr 0x10 with be=0010 and wdata 0x00001100 -> cpu_rdata=0xAABB11DD.
REQ-041 SHALL check out-of-range access: write to addr 4*328 -> no array change, cpu_err=1 the next cycle, cpu_rdata=0.
REQ-042 SHALL check display latency: mem[VID_BASE+5]=0x12345678; vid_req=1 with vid_idx=5 -> next cycle vid_valid=1 and vid_data=0x12345678.
REQ-043 SHALL check a plain clear: fill the region with 0xFFFFFFFF; pulse clr_start -> clr_busy for 257 cycles, clr_done at cycle 257, all region words 0 and word VID_WORDS unchanged.
REQ-044 SHALL check a clear with CPU stalls: 3 CPU writes during CLEAR -> clr_done delayed by exactly 3 cycles and the CPU-written data preserved only where written after the clear passed that word.
REQ-045 SHALL check reset during a clear: assert reset at ptr=100 -> clr_busy=0 immediately; words 100..255 keep their prior values.
